// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters, clamped sync placement, latency-matched blank/sync/DE.
// Define VTG_INTERLACE_EN to enable the interlaced odd/even field variant (progressive otherwise).
module video_timing_gen #(
  parameter int H_ACTIVE = 336,
  parameter int H_FP     = 24,
  parameter int H_SYNC   = 24,
  parameter int H_TOTAL  = 456,
  parameter int V_ACTIVE = 240,
  parameter int V_FP     = 0,
  parameter int V_SYNC   = 3,
  parameter int V_TOTAL  = 262,
  parameter int PIX_LAT  = 1,
  parameter int RGB_W    = 8,
  parameter int SYNC_POL = 0
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             ce_pix,
  input  logic [4:0]       hoffs,
  input  logic [2:0]       voffs,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [8:0]       hpos,
  output logic [8:0]       vpos,
  output logic             line_start,
  output logic             frame_start,
  output logic             hblank,
  output logic             vblank,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [RGB_W-1:0] rgb_out,
  output logic             field
);

  localparam logic [8:0]         H_LAST    = 9'(H_TOTAL - 1);
  localparam logic signed [10:0] HS_NOM    = 11'(H_ACTIVE + H_FP);
  localparam logic signed [10:0] HS_MIN    = 11'(H_ACTIVE);
  localparam logic signed [10:0] HS_MAX    = 11'(H_TOTAL - H_SYNC);
  localparam logic signed [10:0] VS_NOM    = 11'(V_ACTIVE + V_FP);
  localparam logic signed [10:0] VS_MIN    = 11'(V_ACTIVE);
  localparam logic signed [10:0] VS_MAX    = 11'(V_TOTAL - V_SYNC);
  localparam logic [3:0]         PIPE_IDLE = 4'b1100;  // {hb,vb,hs,vs}: blank, sync inactive

  logic [8:0] r_hpos, r_vpos;
  logic       r_line_start, r_frame_start;
  logic [4:0] r_hoffs;
  logic [2:0] r_voffs;
  logic [8:0] w_last_line;
  logic       w_h_wrap, w_v_wrap;

  assign w_h_wrap = (r_hpos == H_LAST);
  assign w_v_wrap = w_h_wrap && (r_vpos == w_last_line);

`ifdef VTG_INTERLACE_EN
  localparam logic [10:0] H_HALF = 11'(H_TOTAL / 2);
  logic r_field;

  // The odd field carries one extra line.
  assign w_last_line = r_field ? 9'(V_TOTAL) : 9'(V_TOTAL - 1);
  assign field       = r_field;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_field <= 1'b0;
    end else if (ce_pix && w_v_wrap) begin
      r_field <= ~r_field;
    end
  end
`else
  assign w_last_line = 9'(V_TOTAL - 1);
  assign field       = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_hpos        <= '0;
      r_vpos        <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_hoffs       <= '0;
      r_voffs       <= '0;
    end else begin
      r_line_start  <= ce_pix && w_h_wrap;
      r_frame_start <= ce_pix && w_v_wrap;
      if (ce_pix) begin
        if (w_h_wrap) begin
          r_hpos <= '0;
          if (w_v_wrap) begin
            r_vpos  <= '0;
            r_hoffs <= hoffs;
            r_voffs <= voffs;
          end else begin
            r_vpos <= r_vpos + 9'd1;
          end
        end else begin
          r_hpos <= r_hpos + 9'd1;
        end
      end
    end
  end

  // Sync start positions from the frame-latched offsets, clamped so the pulse stays in blanking.
  logic signed [10:0] w_hs_raw, w_vs_raw;
  logic [10:0]        w_hs_st, w_vs_st, w_hs_end, w_vs_end, w_h11, w_v11;

  always_comb begin
    w_hs_raw = HS_NOM + ({{6{r_hoffs[4]}}, r_hoffs} << 1);
    w_vs_raw = VS_NOM + {{8{r_voffs[2]}}, r_voffs};
    if (w_hs_raw < HS_MIN)      w_hs_st = HS_MIN;
    else if (w_hs_raw > HS_MAX) w_hs_st = HS_MAX;
    else                        w_hs_st = w_hs_raw;
    if (w_vs_raw < VS_MIN)      w_vs_st = VS_MIN;
    else if (w_vs_raw > VS_MAX) w_vs_st = VS_MAX;
    else                        w_vs_st = w_vs_raw;
    w_hs_end = w_hs_st + 11'(H_SYNC);
    w_vs_end = w_vs_st + 11'(V_SYNC);
    w_h11    = {2'b00, r_hpos};
    w_v11    = {2'b00, r_vpos};
  end

  logic       w_hb, w_vb, w_hs, w_vs;
  logic [3:0] w_raw, w_tap;

  assign w_hb = (r_hpos >= 9'(H_ACTIVE));
  assign w_vb = (r_vpos >= 9'(V_ACTIVE));
  assign w_hs = (w_h11 >= w_hs_st) && (w_h11 < w_hs_end);
`ifdef VTG_INTERLACE_EN
  // Odd-field vsync edges sit half a line later than the even-field ones.
  assign w_vs = r_field ?
                (((w_v11 == w_vs_st) && (w_h11 >= H_HALF)) ||
                 ((w_v11 > w_vs_st) && (w_v11 < w_vs_end)) ||
                 ((w_v11 == w_vs_end) && (w_h11 < H_HALF))) :
                ((w_v11 >= w_vs_st) && (w_v11 < w_vs_end));
`else
  assign w_vs = (w_v11 >= w_vs_st) && (w_v11 < w_vs_end);
`endif
  assign w_raw = {w_hb, w_vb, w_hs, w_vs};

  generate
    if (PIX_LAT == 0) begin : g_nolat
      assign w_tap = w_raw;
    end else begin : g_lat
      logic [3:0] r_pipe [PIX_LAT];
      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < PIX_LAT; i++) r_pipe[i] <= PIPE_IDLE;
        end else if (ce_pix) begin
          r_pipe[0] <= w_raw;
          for (int i = 1; i < PIX_LAT; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_tap = r_pipe[PIX_LAT-1];
    end
  endgenerate

  logic             r_hb, r_vb, r_hs, r_vs, r_de;
  logic [RGB_W-1:0] r_rgb;

  // Pixel and DE load on the same ce so they stay aligned.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_hb  <= 1'b1;
      r_vb  <= 1'b1;
      r_hs  <= 1'b0;
      r_vs  <= 1'b0;
      r_de  <= 1'b0;
      r_rgb <= '0;
    end else if (ce_pix) begin
      r_hb  <= w_tap[3];
      r_vb  <= w_tap[2];
      r_hs  <= w_tap[1];
      r_vs  <= w_tap[0];
      r_de  <= ~(w_tap[3] | w_tap[2]);
      r_rgb <= (w_tap[3] | w_tap[2]) ? '0 : rgb_in;
    end
  end

  assign hpos        = r_hpos;
  assign vpos        = r_vpos;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;
  assign hblank      = r_hb;
  assign vblank      = r_vb;
  assign hsync       = (SYNC_POL != 0) ? r_hs : ~r_hs;
  assign vsync       = (SYNC_POL != 0) ? r_vs : ~r_vs;
  assign de          = r_de;
  assign rgb_out     = r_rgb;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: reduced raster, two instances (PIX_LAT=3 active-low, PIX_LAT=0 active-high).
// A position/arithmetic reference model with a raw-signal history queue predicts every output each cycle.
module tb_video_timing_gen;
  localparam int HA = 20, HFP = 4, HS = 4, HT = 32;
  localparam int VA = 12, VFP = 2, VS = 2, VT = 18;
  localparam int LAT_A = 3, LAT_B = 0;

  typedef struct packed { logic hb, vb, hs, vs; } raw_t;
  localparam raw_t IDLE = 4'b1100;

  typedef struct {
    logic [4:0] ho;
    logic [2:0] vo;
    logic [2:0] mid;
    int         exp_hs;
    int         exp_vs;
  } vec_t;

  // Clock / reset / stimulus
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b0;
  logic [4:0] hoffs = '0;
  logic [2:0] voffs = '0;
  logic [7:0] rgb_in = '0;
  always #5 clk = ~clk;

  logic [8:0] hpos_a, vpos_a, hpos_b, vpos_b;
  logic       ls_a, fs_a, hb_a, vb_a, hs_a, vs_a, de_a, fld_a;
  logic       ls_b, fs_b, hb_b, vb_b, hs_b, vs_b, de_b, fld_b;
  logic [7:0] rgb_a, rgb_b;

  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_TOTAL(VT),
    .PIX_LAT(LAT_A), .RGB_W(8), .SYNC_POL(0)) u_a (
    .clk_sys(clk), .reset_n(rst_n), .ce_pix(ce), .hoffs(hoffs), .voffs(voffs), .rgb_in(rgb_in),
    .hpos(hpos_a), .vpos(vpos_a), .line_start(ls_a), .frame_start(fs_a),
    .hblank(hb_a), .vblank(vb_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
    .rgb_out(rgb_a), .field(fld_a));

  video_timing_gen #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_TOTAL(VT),
    .PIX_LAT(LAT_B), .RGB_W(8), .SYNC_POL(1)) u_b (
    .clk_sys(clk), .reset_n(rst_n), .ce_pix(ce), .hoffs(hoffs), .voffs(voffs), .rgb_in(rgb_in),
    .hpos(hpos_b), .vpos(vpos_b), .line_start(ls_b), .frame_start(fs_b),
    .hblank(hb_b), .vblank(vb_b), .hsync(hs_b), .vsync(vs_b), .de(de_b),
    .rgb_out(rgb_b), .field(fld_b));

  // Reference model state
  int         m_h, m_v, m_field;
  logic [4:0] m_hoffs;
  logic [2:0] m_voffs;
  raw_t       hist[$];
  raw_t       exp_a, exp_b;
  logic [7:0] exp_rgb_a, exp_rgb_b;
  bit         exp_ls, exp_fs;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Raw decode from the sync-placement rules, using linear raster position for vsync.
  function automatic raw_t model_raw();
    raw_t r;
    int ho, vo, hst, vst, lin, half;
    ho = $signed(m_hoffs);
    vo = $signed(m_voffs);
    hst = HA + HFP + 2 * ho;
    if (hst < HA) hst = HA;
    if (hst > HT - HS) hst = HT - HS;
    vst = VA + VFP + vo;
    if (vst < VA) vst = VA;
    if (vst > VT - VS) vst = VT - VS;
    half = (m_field != 0) ? HT / 2 : 0;
    lin = m_v * HT + m_h;
    r.hb = (m_h >= HA);
    r.vb = (m_v >= VA);
    r.hs = (m_h >= hst) && (m_h < hst + HS);
    r.vs = (lin >= vst * HT + half) && (lin < (vst + VS) * HT + half);
    return r;
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_field = 0; m_hoffs = '0; m_voffs = '0;
    hist.delete();
    for (int i = 0; i < 8; i++) hist.push_back(IDLE);
    exp_a = IDLE; exp_b = IDLE;
    exp_rgb_a = '0; exp_rgb_b = '0;
    exp_ls = 1'b0; exp_fs = 1'b0;
  endtask

  task automatic model_ce();
    int lines;
    hist.push_front(model_raw());
    if (hist.size() > 8) void'(hist.pop_back());
    exp_a = hist[LAT_A];
    exp_b = hist[LAT_B];
    exp_rgb_a = (!exp_a.hb && !exp_a.vb) ? rgb_in : 8'd0;
    exp_rgb_b = (!exp_b.hb && !exp_b.vb) ? rgb_in : 8'd0;
    lines = VT + m_field;
    exp_ls = (m_h == HT - 1);
    exp_fs = exp_ls && (m_v == lines - 1);
    if (exp_fs) begin
      m_h = 0; m_v = 0; m_hoffs = hoffs; m_voffs = voffs;
`ifdef VTG_INTERLACE_EN
      m_field = 1 - m_field;
`endif
    end else if (exp_ls) begin
      m_h = 0; m_v++;
    end else begin
      m_h++;
    end
  endtask

  task automatic check_all();
    chk("hpos_a", hpos_a, m_h);          chk("vpos_a", vpos_a, m_v);
    chk("line_start_a", ls_a, exp_ls);   chk("frame_start_a", fs_a, exp_fs);
    chk("hblank_a", hb_a, exp_a.hb);     chk("vblank_a", vb_a, exp_a.vb);
    chk("hsync_a", hs_a, !exp_a.hs);     chk("vsync_a", vs_a, !exp_a.vs);
    chk("de_a", de_a, !(exp_a.hb || exp_a.vb));
    chk("rgb_a", rgb_a, exp_rgb_a);      chk("field_a", fld_a, m_field);
    chk("hpos_b", hpos_b, m_h);          chk("vpos_b", vpos_b, m_v);
    chk("line_start_b", ls_b, exp_ls);   chk("frame_start_b", fs_b, exp_fs);
    chk("hblank_b", hb_b, exp_b.hb);     chk("vblank_b", vb_b, exp_b.vb);
    chk("hsync_b", hs_b, exp_b.hs);      chk("vsync_b", vs_b, exp_b.vs);
    chk("de_b", de_b, !(exp_b.hb || exp_b.vb));
    chk("rgb_b", rgb_b, exp_rgb_b);      chk("field_b", fld_b, m_field);
  endtask

  // Driver: one clk_sys cycle, inputs changed on the falling edge, outputs checked 1 after the rising edge.
  task automatic step(input bit ce_v);
    @(negedge clk);
    ce = ce_v;
    rgb_in = 8'($urandom);
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (ce_v) model_ce();
    else begin exp_ls = 1'b0; exp_fs = 1'b0; end
    #1 check_all();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    ce = 1'b0;
    #1 model_reset();
    check_all();
    repeat (n) step(1'($urandom_range(0, 1)));
    @(negedge clk);
    ce = 1'b0;
    rst_n = 1'b1;
  endtask

  // One frame at ce every 2 clk: measure sync starts, line count and DE count on instance A.
  task automatic run_frame(input vec_t v);
    int  idx, ls_cnt, de_cnt, hs_idx, vs_idx, budget;
    bit  prev_hs, prev_vs, hs_act, vs_act;
    hoffs = v.ho;
    voffs = v.vo;
    budget = 0;
    do begin
      step(1'b0); step(1'b1); budget++;
    end while (!exp_fs && budget < 2000);
    if (!exp_fs) begin
      chk("frame_start_timeout", 0, 1);
      return;
    end
    idx = 0; ls_cnt = int'(ls_a); de_cnt = int'(de_a);
    hs_idx = -1; vs_idx = -1;
    prev_hs = !hs_a; prev_vs = !vs_a;
    while (!(m_h == HT - 1 && m_v == VT + m_field - 1) && idx < 2000) begin
      step(1'b0); step(1'b1); idx++;
      if (m_v == 3 && m_h == 0) voffs = v.mid;
      ls_cnt += int'(ls_a);
      de_cnt += int'(de_a);
      hs_act = !hs_a; vs_act = !vs_a;
      if (hs_act && !prev_hs && hs_idx < 0) hs_idx = idx;
      if (vs_act && !prev_vs && vs_idx < 0) vs_idx = idx;
      prev_hs = hs_act; prev_vs = vs_act;
    end
    chk("tbl_hs_st", hs_idx - (LAT_A + 1), v.exp_hs);
    chk("tbl_vs_st", (vs_idx - (LAT_A + 1)) / HT, v.exp_vs);
    chk("tbl_lines", ls_cnt, VT + m_field);
    chk("tbl_de_cnt", de_cnt, HA * VA);
  endtask

  vec_t tbl[6];

  initial begin
    // hs_st = 24 + 2*hoffs in [20,28]; vs_st = 14 + voffs in [12,16]
    tbl[0] = '{5'd0,  3'd0, 3'd0, 24, 14};
    tbl[1] = '{5'd2,  3'd1, 3'd3, 28, 15};  // mid-frame voffs change must not move this frame
    tbl[2] = '{5'd3,  3'd3, 3'd3, 28, 16};  // both clamp high
    tbl[3] = '{5'h1E, 3'h7, 3'h7, 20, 13};  // hoffs=-2 lands exactly on the low bound
    tbl[4] = '{5'h10, 3'h4, 3'h4, 20, 12};  // both clamp low
    tbl[5] = '{5'd1,  3'd2, 3'd2, 26, 16};

    model_reset();
    repeat (6) step(1'($urandom_range(0, 1)));
    @(negedge clk);
    ce = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_frame(tbl[i]);

    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 250) begin
        hoffs = 5'($urandom);
        voffs = 3'($urandom);
      end
      if (i == 1700) do_reset(3);
      step($urandom_range(0, 3) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
